// File: rtl/rv32i_types.sv
// Shared types for the dispatch path: functional-unit select,
// dispatch FSM states and the flush-hold saturation helper.
package rv32i_types;

   typedef enum logic [1:0] {
      FU_ALU  = 2'd0,
      FU_BR   = 2'd1,
      FU_LSU  = 2'd2,
      FU_NONE = 2'd3
   } fu_sel_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } disp_state_t;

   localparam int HOLD_W   = 3;
   localparam int HOLD_MAX = 7;

   function automatic logic [HOLD_W-1:0] sat_hold(input int v);
      logic [31:0] u;
      u = v;
      if (v > HOLD_MAX) return 3'd7;
      else if (v < 0) return 3'd0;
      else return u[HOLD_W-1:0];
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Enabled up-counter; wraps modulo 2^WIDTH, or sticks at all-ones
// when WRAP is cleared.
module sat_counter #(
   parameter int WIDTH = 32,
   parameter bit WRAP  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (en && (WRAP || count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/dispatch_ctrl.sv
// In-order dispatch sequencer: ROB alloc, rename, operand read and
// RS load in one cycle, with back-pressure stall and flush quiesce.
module dispatch_ctrl
   import rv32i_types::*;
#(
   parameter int ROB_SIZE   = 16,
   parameter int FLUSH_HOLD = 2,
   parameter int CNT_W      = 32,
   localparam int TAG_W     = $clog2(ROB_SIZE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             iq_valid,
   input  logic [4:0]       iq_rs1,
   input  logic [4:0]       iq_rs2,
   input  logic [4:0]       iq_rd,
   input  logic             iq_writes_rd,
   input  logic [1:0]       iq_fu,
   output logic             iq_pop,
   input  logic             rob_full,
   input  logic [TAG_W-1:0] rob_tail,
   output logic             rob_alloc,
   input  logic [2:0]       rs_full,
   output logic [2:0]       rs_load,
   output logic             rf_dispatch,
   output logic [TAG_W-1:0] rf_rob_entry,
   output logic [4:0]       rf_rs1_s,
   output logic [4:0]       rf_rs2_s,
   output logic [4:0]       rf_rd_s,
   input  logic             flush,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] disp_count
);

   disp_state_t       state;
   logic [HOLD_W-1:0] hold;
   fu_sel_t           fu;
   logic              rs_blk;
   logic              blocked;
   logic              quiet;
   logic              go;
   logic              stall_en;
   logic [CNT_W-1:0]  stall_raw;
   logic [CNT_W-1:0]  disp_raw;

   assign fu = fu_sel_t'(iq_fu);

   always_comb begin
      rs_blk = 1'b0;
      unique case (fu)
         FU_ALU:  rs_blk = rs_full[0];
         FU_BR:   rs_blk = rs_full[1];
         FU_LSU:  rs_blk = rs_full[2];
         FU_NONE: rs_blk = 1'b0;
         default: rs_blk = 1'b0;
      endcase
   end

   assign blocked  = rob_full | rs_blk;
   assign quiet    = flush | (state == FLUSH);
   assign go       = rst & iq_valid & ~blocked & ~quiet;
   assign stall_en = iq_valid & blocked & ~quiet;

   assign iq_pop      = go;
   assign rob_alloc   = go;
   assign rf_dispatch = go;

   always_comb begin
      rs_load = '0;
      if (go && fu != FU_NONE) rs_load = 3'b001 << iq_fu;
   end

   // Operand indices pass straight through; rd=0 suppresses the rename.
   assign rf_rob_entry = rst ? rob_tail : '0;
   assign rf_rs1_s     = rst ? iq_rs1 : '0;
   assign rf_rs2_s     = rst ? iq_rs2 : '0;
   assign rf_rd_s      = (iq_writes_rd & go) ? iq_rd : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= RUN;
         hold  <= '0;
      end else if (flush) begin
         state <= FLUSH;
         hold  <= sat_hold(FLUSH_HOLD);
      end else begin
         unique case (state)
            RUN:
               if (iq_valid && blocked) state <= STALL;
            STALL:
               if (!iq_valid || !blocked) state <= RUN;
            FLUSH: begin
               hold <= hold - HOLD_W'(1);
               if (hold <= HOLD_W'(1)) state <= RUN;
            end
            default:
               state <= RUN;
         endcase
      end
   end

   sat_counter #(.WIDTH(CNT_W), .WRAP(1'b1)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (stall_en),
      .count (stall_raw)
   );

   sat_counter #(.WIDTH(CNT_W), .WRAP(1'b1)) u_disp_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (go),
      .count (disp_raw)
   );

   assign stall_cycles = rst ? stall_raw : '0;
   assign disp_count   = rst ? disp_raw : '0;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl with a cycle-level reference model
// compared on every falling edge, plus literal checks per scenario.
module tb_dispatch_ctrl;

   localparam int ROB_SIZE   = 16;
   localparam int FLUSH_HOLD = 2;
   localparam int CNT_W      = 32;
   localparam int TAG_W      = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             iq_valid;
   logic [4:0]       iq_rs1, iq_rs2, iq_rd;
   logic             iq_writes_rd;
   logic [1:0]       iq_fu;
   logic             iq_pop;
   logic             rob_full;
   logic [TAG_W-1:0] rob_tail;
   logic             rob_alloc;
   logic [2:0]       rs_full;
   logic [2:0]       rs_load;
   logic             rf_dispatch;
   logic [TAG_W-1:0] rf_rob_entry;
   logic [4:0]       rf_rs1_s, rf_rs2_s, rf_rd_s;
   logic             flush;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] disp_count;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   dispatch_ctrl #(
      .ROB_SIZE   (ROB_SIZE),
      .FLUSH_HOLD (FLUSH_HOLD),
      .CNT_W      (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .iq_valid     (iq_valid),
      .iq_rs1       (iq_rs1),
      .iq_rs2       (iq_rs2),
      .iq_rd        (iq_rd),
      .iq_writes_rd (iq_writes_rd),
      .iq_fu        (iq_fu),
      .iq_pop       (iq_pop),
      .rob_full     (rob_full),
      .rob_tail     (rob_tail),
      .rob_alloc    (rob_alloc),
      .rs_full      (rs_full),
      .rs_load      (rs_load),
      .rf_dispatch  (rf_dispatch),
      .rf_rob_entry (rf_rob_entry),
      .rf_rs1_s     (rf_rs1_s),
      .rf_rs2_s     (rf_rs2_s),
      .rf_rd_s      (rf_rd_s),
      .flush        (flush),
      .stall_cycles (stall_cycles),
      .disp_count   (disp_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: remaining quiet cycles after a flush plus counters.
   int               m_hold = 0;
   logic [CNT_W-1:0] m_stall = '0;
   logic [CNT_W-1:0] m_disp = '0;

   function automatic bit m_blocked();
      bit rb;
      rb = 1'b0;
      if (iq_fu != 2'd3) rb = rs_full[iq_fu];
      return rob_full || rb;
   endfunction

   function automatic bit m_quiet();
      return flush || (m_hold > 0);
   endfunction

   function automatic bit m_go();
      return rst && iq_valid && !m_blocked() && !m_quiet();
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         m_hold  <= 0;
         m_stall <= '0;
         m_disp  <= '0;
      end else begin
         if (m_go()) m_disp <= m_disp + 1;
         if (iq_valid && m_blocked() && !m_quiet()) m_stall <= m_stall + 1;
         if (flush) m_hold <= FLUSH_HOLD;
         else if (m_hold > 0) m_hold <= m_hold - 1;
      end
   end

   logic       e_go;
   logic [2:0] e_rs;
   always @(negedge clk) begin
      if (chk_on) begin
         e_go = m_go();
         e_rs = 3'b000;
         if (e_go && iq_fu != 2'd3) e_rs[iq_fu] = 1'b1;
         chk("m_pop", iq_pop, e_go);
         chk("m_alloc", rob_alloc, e_go);
         chk("m_disp", rf_dispatch, e_go);
         chk("m_rsload", rs_load, e_rs);
         chk("m_rd", rf_rd_s, (e_go && iq_writes_rd) ? iq_rd : 5'd0);
         chk("m_tag", rf_rob_entry, rst ? rob_tail : 4'd0);
         chk("m_rs1", rf_rs1_s, rst ? iq_rs1 : 5'd0);
         chk("m_rs2", rf_rs2_s, rst ? iq_rs2 : 5'd0);
         chk("m_stallcnt", stall_cycles, rst ? m_stall : '0);
         chk("m_dispcnt", disp_count, rst ? m_disp : '0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; iq_valid = 1'b0; iq_rs1 = '0; iq_rs2 = '0;
      iq_rd = '0; iq_writes_rd = 1'b0; iq_fu = '0; rob_full = 1'b0;
      rob_tail = '0; rs_full = '0; flush = 1'b0;
      step(); chk_on = 1'b1; step();
      // Valid head during reset must not leak out
      iq_valid = 1'b1; iq_fu = 2'd0; iq_rs1 = 5'd1; iq_rs2 = 5'd2;
      iq_rd = 5'd5; iq_writes_rd = 1'b1; rob_tail = 4'd3;
      neg();
      chk("rst_pop", iq_pop, 1'b0);
      chk("rst_tag", rf_rob_entry, 4'd0);
      chk("rst_rs1", rf_rs1_s, 5'd0);
      chk("rst_disp", disp_count, 32'd0);
      chk("rst_stall", stall_cycles, 32'd0);
      // add x5,x1,x2 with rob_tail=3
      step(); rst = 1'b1;
      neg();
      chk("add_pop", iq_pop, 1'b1);
      chk("add_alloc", rob_alloc, 1'b1);
      chk("add_rsload", rs_load, 3'b001);
      chk("add_rd", rf_rd_s, 5'd5);
      chk("add_tag", rf_rob_entry, 4'd3);
      step(); iq_valid = 1'b0;
      neg();
      chk("add_cnt", disp_count, 32'd1);
      // LSU head against a full LSU RS for 4 cycles
      step(); iq_valid = 1'b1; iq_fu = 2'd2; rs_full = 3'b100; iq_rd = 5'd6;
      for (int i = 0; i < 4; i++) begin
         neg();
         chk("lsu_blk_pop", iq_pop, 1'b0);
         chk("lsu_blk_rs", rs_load, 3'b000);
         step();
      end
      rs_full = 3'b000;
      neg();
      chk("lsu_stall", stall_cycles, 32'd4);
      chk("lsu_rsload", rs_load, 3'b100);
      chk("lsu_pop", iq_pop, 1'b1);
      step(); iq_valid = 1'b0;
      neg();
      chk("lsu_cnt", disp_count, 32'd2);
      // beq: no rename, branch RS
      step(); iq_valid = 1'b1; iq_fu = 2'd1; iq_writes_rd = 1'b0; iq_rd = 5'd7;
      neg();
      chk("beq_rd", rf_rd_s, 5'd0);
      chk("beq_disp", rf_dispatch, 1'b1);
      chk("beq_rsload", rs_load, 3'b010);
      // ROB-only op ignores RS full; then ROB full blocks it
      step(); iq_fu = 2'd3; rs_full = 3'b111; iq_writes_rd = 1'b1; iq_rd = 5'd9;
      neg();
      chk("none_rsload", rs_load, 3'b000);
      chk("none_pop", iq_pop, 1'b1);
      chk("none_rd", rf_rd_s, 5'd9);
      step(); rob_full = 1'b1;
      neg();
      chk("robfull_pop", iq_pop, 1'b0);
      step(); rob_full = 1'b0; rs_full = 3'b000; iq_valid = 1'b0;
      neg();
      chk("robfull_stall", stall_cycles, 32'd5);
      chk("robfull_cnt", disp_count, 32'd4);
      // Single flush; blocked head during hold is not a stall
      step(); iq_valid = 1'b1; iq_fu = 2'd0; flush = 1'b1;
      neg(); chk("f1_c0", iq_pop, 1'b0);
      step(); flush = 1'b0; rob_full = 1'b1;
      neg(); chk("f1_c1", iq_pop, 1'b0);
      step(); rob_full = 1'b0;
      neg(); chk("f1_c2", iq_pop, 1'b0);
      step();
      neg();
      chk("f1_c3", iq_pop, 1'b1);
      chk("f1_stall", stall_cycles, 32'd5);
      step(); iq_valid = 1'b0;
      neg(); chk("f1_cnt", disp_count, 32'd5);
      // Flush re-armed during hold pushes dispatch out one cycle
      step(); iq_valid = 1'b1; flush = 1'b1;
      neg(); chk("f2_c0", iq_pop, 1'b0);
      step();
      neg(); chk("f2_c1", iq_pop, 1'b0);
      step(); flush = 1'b0;
      neg(); chk("f2_c2", iq_pop, 1'b0);
      step();
      neg(); chk("f2_c3", iq_pop, 1'b0);
      step();
      neg();
      chk("f2_c4", iq_pop, 1'b1);
      chk("f2_stall", stall_cycles, 32'd5);
      step(); iq_valid = 1'b0;
      neg(); chk("f2_cnt", disp_count, 32'd6);
      // Reset in the middle of a ROB stall
      step(); iq_valid = 1'b1; rob_full = 1'b1;
      neg(); chk("rs_blk0", iq_pop, 1'b0);
      step();
      neg(); chk("rs_stall", stall_cycles, 32'd6);
      step(); rst = 1'b0;
      neg();
      chk("rs_pop", iq_pop, 1'b0);
      chk("rs_alloc", rob_alloc, 1'b0);
      chk("rs_st0", stall_cycles, 32'd0);
      chk("rs_dc0", disp_count, 32'd0);
      step(); rst = 1'b1; rob_full = 1'b0;
      neg();
      chk("rs_resume", iq_pop, 1'b1);
      chk("rs_st_after", stall_cycles, 32'd0);
      chk("rs_dc_after", disp_count, 32'd0);
      step(); iq_valid = 1'b0;
      neg(); chk("rs_dc1", disp_count, 32'd1);
      step(); step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dispatch_ctrl.md
# dispatch_ctrl

In-order dispatch sequencer for the out-of-order core: each cycle it takes at most one decoded instruction from the instruction queue head and performs four actions together. It allocates a ROB tag, renames the destination in the register file/RAT, reads source operands or tags, and loads one reservation station. It stalls on ROB or reservation-station back-pressure. It also quiesces dispatch around a branch-mispredict flush so no rename is written into a table that is being cleared.

## Interface
- `ROB_SIZE`, 16: ROB entries; tag width `TAG_W = $clog2(ROB_SIZE)`.
- `FLUSH_HOLD`, 2: cycles dispatch stays blocked after the flush cycle (1..7).
- `CNT_W`, 32: width of performance counters.

- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, synchronous, active-low (asserted when 0).
- `iq_valid`  in  1  instruction queue head valid.
- `iq_rs1`, `iq_rs2`, `iq_rd`  in  5 each  architectural register indices.
- `iq_writes_rd`  in  1  instruction writes `rd`.
- `iq_fu`  in  2  target: 0 ALU RS, 1 branch/compare RS, 2 load/store RS, 3 ROB-only (completes at decode).
- `iq_pop`  out  1  head consumed this cycle.
- `rob_full`  in  1  ROB cannot accept an entry.
- `rob_tail`  in  TAG_W  tag of next free ROB entry.
- `rob_alloc`  out  1  allocate ROB entry `rob_tail`.
- `rs_full`  in  3  per-RS full, bit index = `iq_fu`.
- `rs_load`  out  3  one-hot RS load strobe.
- `rf_dispatch`  out  1  rename strobe to register file.
- `rf_rob_entry`  out  TAG_W  tag written into RAT.
- `rf_rs1_s`, `rf_rs2_s`, `rf_rd_s`  out  5 each  register file read/rename indices.
- `flush`  in  1  registered mispredict flush from the register file/commit path.
- `stall_cycles`  out  CNT_W  cycles the head was valid but blocked (not counting flush).
- `disp_count`  out  CNT_W  instructions dispatched.

## Operation
- States: `RUN`, `STALL`, `FLUSH`. Reset enters `RUN` with the hold counter at 0 and both perf counters at 0.
- `blocked = rob_full | (iq_fu != 3 & rs_full[iq_fu])`.
- `go = iq_valid & !blocked & !flush & state != FLUSH`.
- When `go` is high, `iq_pop`, `rob_alloc`, and `rf_dispatch` are all 1 in the same cycle.
- When `go` is high, `rs_load = 1 << iq_fu` for `iq_fu` 0..2, and `rs_load = 0` for `iq_fu = 3`.
- `rf_rob_entry = rob_tail` always.
- `rf_rs1_s = iq_rs1` and `rf_rs2_s = iq_rs2` always, because the operand read is combinational in the register file.
- `rf_rd_s = (iq_writes_rd & go) ? iq_rd : 0`. A value of 0 suppresses the rename, because the register file ignores `rd = x0`.
- Transitions:
  - `RUN`→`STALL` when `iq_valid & blocked & !flush`.
  - `STALL`→`RUN` when `!iq_valid | !blocked`. Dispatch is allowed in the same cycle `STALL` is left.
  - From any state, `flush`→`FLUSH`, and the hold counter is loaded with `FLUSH_HOLD`.
  - `FLUSH` decrements the hold counter each cycle. It goes to `RUN` on the cycle the counter is 1, so dispatch resumes when the counter reaches 0.
- `flush` while already in `FLUSH` reloads the hold counter.
- `stall_cycles` increments in every cycle with `iq_valid & blocked & !flush & state != FLUSH`.
- `disp_count` increments in every `go` cycle.
- Both counters wrap modulo 2^CNT_W.
- When the hold counter is loaded or reset, values above 7 are saturated to 7.

## Timing
- Dispatch latency is 0 cycles: all strobes are combinational from the head of the queue and the current state. Throughput is one instruction per cycle.
- Every strobe is a single-cycle pulse per instruction. The controller never asserts `iq_pop` without `rob_alloc`.
- A `flush` cycle blocks dispatch in that same cycle, because the register file clears its tags on that edge. Dispatch is then blocked for `FLUSH_HOLD` further cycles. The first possible `go` is cycle F+FLUSH_HOLD+1, where F is the flush cycle.
- Reset while active: all outputs are combinationally 0 whenever `rst == 0`, and the state returns to `RUN` on that edge.
- If `rob_full` and `rs_full` change in the same cycle, only the current-cycle values matter. There is no registered decision.

## Structure
- `rv32i_types` package gains:
  - an `fu_sel_t` enum (`FU_ALU`, `FU_BR`, `FU_LSU`, `FU_NONE`);
  - a `disp_state_t` enum.
- Tag width is derived locally from `ROB_SIZE`, matching the register file.
- One sub-module, `sat_counter` (parameter width, enable, wrap), is instantiated twice for the perf counters.
- All other logic lives in `dispatch_ctrl`.

## Test plan
- Reset, then ALU `add x5,x1,x2` with `rob_tail=3`: in the same cycle `iq_pop=1`, `rob_alloc=1`, `rs_load=3'b001`, `rf_rd_s=5`, `rf_rob_entry=3`, and `disp_count` becomes 1.
- `rs_full=3'b100` with an LSU head for 4 cycles, then clear: no strobes for 4 cycles, `stall_cycles=4`, and dispatch happens on cycle 5 with `rs_load=3'b100`.
- Head `beq` with `iq_writes_rd=0` and `iq_rd=7`: `rf_rd_s=0`, `rf_dispatch=1`, `rs_load=3'b010`.
- `flush` pulse at cycle 10 with the queue continuously valid: no `go` in cycles 10–12, first dispatch at cycle 13 (`FLUSH_HOLD=2`), and `stall_cycles` unchanged.
- Second `flush` at cycle 11 during the hold: the first dispatch moves to cycle 14.
- `rst=0` asserted mid-stall: all outputs are 0 and both counters read 0 after the edge; with `rst=1`, dispatch resumes the next cycle.
